// File: rtl/oc8051_cxrom_word_fetcher.sv
`timescale 1ns/1ps
// oc8051_cxrom_word_fetcher
//
// Fetches one 32-bit code word for the symbolic code-ROM capture block by
// reading four consecutive bytes from the byte-wide program ROM over a
// rom_rd/rom_ack handshake. The bytes are assembled little-endian and the
// finished word is presented for a single cycle, tagged with its base address.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   req          fetch request, sampled only while idle
//   req_addr     byte address of word byte 0
//   busy         high whenever a fetch is in progress (ISSUE or DONE)
//   word_valid   one-cycle pulse; word_out/word_addr carry the new word
//   word_out     assembled word {byte3, byte2, byte1, byte0}
//   word_addr    base address of word_out
//   rom_rd       byte read request to the program ROM
//   rom_addr     byte address of the current ROM read (0 when not reading)
//   rom_data     ROM read data, valid with rom_ack
//   rom_ack      ROM completion, honoured only while rom_rd is high
//   timeout_err  one-cycle pulse when a fetch is aborted on a stuck byte
//
// TIMEOUT is the number of consecutive unacknowledged cycles on one byte
// after which the fetch is abandoned; 0 disables the abort.
module oc8051_cxrom_word_fetcher #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] req_addr,
  output logic        busy,
  output logic        word_valid,
  output logic [31:0] word_out,
  output logic [15:0] word_addr,
  output logic        rom_rd,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ack,
  output logic        timeout_err
);

  // The wait counter only has to reach TIMEOUT-1: the abort fires in the
  // cycle that would otherwise be the TIMEOUT-th unacknowledged one.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       base;
  logic [1:0]        idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [23:0]       asm_lo;     // bytes 0..2; byte 3 goes straight into word_out

  logic start;
  logic capture;
  logic finish;
  logic abort;
  logic wait_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    rom_rd     = 1'b0;
    word_valid = 1'b0;
    start      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    wait_hit   = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    case (state)
      IDLE: begin
        if (req) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy   = 1'b1;
        rom_rd = 1'b1;
        // An ack in the final allowed cycle still completes the byte.
        if (rom_ack) begin
          capture = 1'b1;
          if (idx == 2'd3) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end else if (wait_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // 16-bit add wraps naturally across the top of the code space.
    rom_addr = rom_rd ? (base + {14'd0, idx}) : 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base        <= 16'd0;
      idx         <= 2'd0;
      wait_cnt    <= '0;
      asm_lo      <= 24'd0;
      word_out    <= 32'd0;
      word_addr   <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;

      if (start) begin
        base     <= req_addr;
        idx      <= 2'd0;
        wait_cnt <= '0;
      end

      if (capture) begin
        wait_cnt <= '0;
        case (idx)
          2'd0:    asm_lo[7:0]   <= rom_data;
          2'd1:    asm_lo[15:8]  <= rom_data;
          2'd2:    asm_lo[23:16] <= rom_data;
          default: asm_lo        <= asm_lo;
        endcase
        if (!finish) begin
          idx <= idx + 2'd1;
        end
      end else if (rom_rd) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      // The word is published on entry to DONE so it is visible with word_valid.
      if (finish) begin
        word_out  <= {rom_data, asm_lo};
        word_addr <= base;
        idx       <= 2'd0;
      end

      // A partial word is simply dropped; word_out is left untouched.
      if (abort) begin
        idx      <= 2'd0;
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_oc8051_cxrom_word_fetcher.sv
`timescale 1ns/1ps
module tb_oc8051_cxrom_word_fetcher;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [15:0] req_addr;
  logic        busy;
  logic        word_valid;
  logic [31:0] word_out;
  logic [15:0] word_addr;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ack;
  logic        timeout_err;

  oc8051_cxrom_word_fetcher #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .busy(busy), .word_valid(word_valid), .word_out(word_out), .word_addr(word_addr),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ack(rom_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model state: ROM contents, per-byte wait schedule, observations.
  logic [7:0]  mem [0:65535];
  int          sched [4];
  int          byte_no;
  int          waited;
  logic [15:0] served [$];
  int          nvalid;
  int          ntmo;
  int          cyc;
  logic        prev_rd;
  logic        prev_ack;
  logic [15:0] prev_addr;
  logic [31:0] last_word;
  logic [15:0] last_addr;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [15:0] b);
    logic [15:0] a1, a2, a3;
    a1 = b + 16'd1;
    a2 = b + 16'd2;
    a3 = b + 16'd3;
    return {mem[a3], mem[a2], mem[a1], mem[b]};
  endfunction

  // One clock: sample outputs at the falling edge, then play the ROM for the
  // next rising edge. The ROM acks a byte once it has stalled sched[byte] cycles.
  task automatic cycle();
    int need;
    @(negedge clk);
    cyc++;
    if (word_valid === 1'b1) nvalid++;
    if (timeout_err === 1'b1) ntmo++;
    if (rom_rd === 1'b1) begin
      if (prev_rd && !prev_ack) check("addr_stable", {16'd0, rom_addr}, {16'd0, prev_addr});
      need = (byte_no < 4) ? sched[byte_no] : 0;
      if (waited >= need) begin
        rom_ack  = 1'b1;
        rom_data = mem[rom_addr];
        served.push_back(rom_addr);
        byte_no++;
        waited = 0;
      end else begin
        rom_ack  = 1'b0;
        rom_data = 8'($urandom);
        waited++;
      end
    end else begin
      rom_ack  = 1'($urandom_range(0, 1));
      rom_data = 8'($urandom);
    end
    prev_rd   = rom_rd;
    prev_ack  = rom_ack;
    prev_addr = rom_addr;
  endtask

  task automatic arm(input int w0, input int w1, input int w2, input int w3);
    sched[0] = w0; sched[1] = w1; sched[2] = w2; sched[3] = w3;
    byte_no = 0; waited = 0; nvalid = 0; ntmo = 0;
    served.delete();
  endtask

  task automatic do_fetch(input logic [15:0] b, input int w0, input int w1, input int w2,
                          input int w3, input bit busy_req);
    int t0;
    int exp_lat;
    bit got;
    logic [31:0] ew;
    arm(w0, w1, w2, w3);
    exp_lat = 5 + w0 + w1 + w2 + w3;
    ew  = exp_word(b);
    t0  = cyc;
    got = 1'b0;
    req = 1'b1;
    req_addr = b;
    for (int k = 1; k <= 40 && !got; k++) begin
      cycle();
      req = 1'b0;
      req_addr = 16'($urandom);
      if (busy_req && (cyc == t0 + 2 || cyc == t0 + 5)) req = 1'b1;
      if (k == 1) check("busy_after_req", {31'd0, busy}, 32'd1);
      if (word_valid === 1'b1) begin
        got = 1'b1;
        check("latency", cyc - t0, exp_lat);
        check("word_out", word_out, ew);
        check("word_addr", {16'd0, word_addr}, {16'd0, b});
        check("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
    if (!got) check("word_valid_seen", 32'd0, 32'd1);
    check("served_count", served.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < served.size()) check("rom_addr_seq", {16'd0, served[i]}, {16'd0, b + 16'(i)});
    end
    cycle();
    req = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("valid_once", nvalid, 1);
    last_word = ew;
    last_addr = b;
  endtask

  task automatic do_timeout(input logic [15:0] b, input int w0);
    int t0;
    int seen;
    arm(w0, 1000000, 0, 0);
    t0   = cyc;
    seen = -1;
    req  = 1'b1;
    req_addr = b;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      req = 1'b0;
      if (timeout_err === 1'b1 && seen < 0) begin
        seen = cyc - t0;
        check("tmo_busy_low", {31'd0, busy}, 32'd0);
      end
    end
    check("tmo_cycle", seen, 6 + w0);
    check("tmo_pulses", ntmo, 1);
    check("tmo_no_valid", nvalid, 0);
    check("tmo_word_kept", word_out, last_word);
    check("tmo_addr_kept", {16'd0, word_addr}, {16'd0, last_addr});
    check("tmo_rom_rd_low", {31'd0, rom_rd}, 32'd0);
    check("tmo_served", served.size(), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_word"}, word_out, 32'd0);
    check({tag, "_waddr"}, {16'd0, word_addr}, 32'd0);
    check({tag, "_rd"}, {31'd0, rom_rd}, 32'd0);
    check({tag, "_raddr"}, {16'd0, rom_addr}, 32'd0);
    check({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    prev_rd = 1'b0; prev_ack = 1'b0; prev_addr = 16'd0;
    last_word = 32'd0; last_addr = 16'd0;
    rst = 1'b1; req = 1'b0; req_addr = 16'd0; rom_ack = 1'b0; rom_data = 8'd0;
    arm(0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;

    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    cycle();
    cycle();

    // Zero-wait fetch with known contents.
    do_fetch(16'h0100, 0, 0, 0, 0, 1'b0);
    check("known_word", last_word, 32'h44332211);
    check("known_word_dut", word_out, 32'h44332211);

    // Address wrap at the top of the code space.
    do_fetch(16'hFFFE, 0, 0, 0, 0, 1'b0);

    // Variable wait 0,3,1,0.
    do_fetch(16'h1234, 0, 3, 1, 0, 1'b0);

    // Requests while busy are ignored; the following call is the T+6 request.
    do_fetch(16'h2000, 0, 0, 0, 0, 1'b1);
    do_fetch(16'h2004, 0, 0, 0, 0, 1'b0);

    // Timeout on byte 1.
    do_timeout(16'h3000, 0);
    do_timeout(16'h3100, 2);

    // Reset while idx=2.
    arm(0, 0, 0, 0);
    req = 1'b1;
    req_addr = 16'h0200;
    cycle();
    req = 1'b0;
    cycle();
    cycle();
    check("mid_rd", {31'd0, rom_rd}, 32'd1);
    check("mid_addr", {16'd0, rom_addr}, 32'h0202);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    prev_rd = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
    check("midrst_no_valid", nvalid, 0);
    check("midrst_no_tmo", ntmo, 0);
    last_word = 32'd0;
    last_addr = 16'd0;
    do_fetch(16'h0200, 0, 0, 0, 0, 1'b0);

    // Randomized fetches, waits kept below the abort threshold.
    for (int n = 0; n < 12; n++) begin
      do_fetch(16'($urandom), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
               $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)));
    end
    do_fetch(16'hFFFD, $urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom_range(0, 3), 1'b0);
    do_timeout(16'($urandom), $urandom_range(0, 3));
    do_fetch(16'($urandom), 0, 0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
